multi_echo_ranger: RTL and testbench

//  Parametrised N-channel ultrasonic ranger controller; generalises the single-sensor echo path.

---
 rtl/multi_echo_ranger_pkg.sv | 41 ++++
 rtl/multi_echo_ranger_us_tick_gen.sv | 27 ++
 rtl/multi_echo_ranger.sv | 179 +++++++++++++++++
 tb/tb_multi_echo_ranger.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_echo_ranger_pkg.sv
// Shared FSM encoding and channel-pick helpers for the multi-channel echo ranger.
package multi_echo_ranger_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE,
      ST_GAP
   } state_t;

   localparam int unsigned MAX_CH = 8;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Lowest set bit of mask at or above 'from'; MAX_CH when none remains.
   function automatic int unsigned pick_ch(input logic [MAX_CH-1:0] mask,
                                           input int unsigned from);
      int unsigned sel;
      logic        found;
      sel   = MAX_CH;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_CH; i++) begin
         if (!found && i >= from && mask[i]) begin
            sel   = i;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/multi_echo_ranger_us_tick_gen.sv
// Free-running 1 us tick prescaler; CLR realigns the phase so TRIG spans whole ticks.
module us_tick_gen #(
   parameter int unsigned TICK_DIV = 100
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned W = $clog2(TICK_DIV);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt <= '0;
      end else if (CLR || cnt == W'(TICK_DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign TICK = (cnt == W'(TICK_DIV - 1));

endmodule

// File: rtl/multi_echo_ranger.sv
// N-channel ultrasonic ranger: round-robin TRIG, echo width in us, timeout flagging,
// single-shot or continuous sweeps over an enable mask.
module multi_echo_ranger
   import multi_echo_ranger_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned TICK_DIV   = 100,
   parameter int unsigned TRIG_US    = 10,
   parameter int unsigned TIMEOUT_US = 30000,
   parameter int unsigned GAP_US     = 60000,
   parameter int unsigned DIST_W     = 16
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          MODE,
   input  logic                          START,
   input  logic [NUM_CH-1:0]             CH_EN,
   input  logic [NUM_CH-1:0]             ECHO,
   output logic [NUM_CH-1:0]             TRIG,
   output logic                          BUSY,
   output logic [ch_width(NUM_CH)-1:0]   CUR_CH,
   output logic [NUM_CH*DIST_W-1:0]      RANGE,
   output logic [NUM_CH-1:0]             RANGE_VLD,
   output logic [NUM_CH-1:0]             TMO,
   output logic                          SWEEP_DONE
);

   localparam int unsigned CH_W  = ch_width(NUM_CH);
   localparam int unsigned CNT_W = $clog2(max3(TRIG_US, TIMEOUT_US, GAP_US) + 1);

   state_t                   state, next_state;
   logic [NUM_CH-1:0]        echo_s1, echo_s2, echo_s3;
   logic                     tick, clr;
   logic [CNT_W-1:0]         us_cnt;
   logic [DIST_W-1:0]        meas_cnt, meas_next;
   logic [CH_W-1:0]          cur_ch;
   logic [MAX_CH-1:0]        mask;
   logic [3:0]               first_pick, next_pick;
   logic                     any_en, has_next;
   logic                     rise, fall, trig_done, tmo_hit, gap_done;
   logic [NUM_CH*DIST_W-1:0] range_r;
   logic [NUM_CH-1:0]        tmo_r, vld_r;
   logic                     done_r;

   us_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK    (CLK),
      .RESET_N(RESET_N),
      .CLR    (clr),
      .TICK   (tick)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
         echo_s3 <= '0;
      end else begin
         echo_s1 <= ECHO;
         echo_s2 <= echo_s1;
         echo_s3 <= echo_s2;
      end
   end

   always_comb begin
      mask = '0;
      mask[NUM_CH-1:0] = CH_EN;
   end

   assign any_en     = |CH_EN;
   assign first_pick = 4'(pick_ch(mask, 0));
   assign next_pick  = 4'(pick_ch(mask, 32'(cur_ch) + 1));
   assign has_next   = (32'(next_pick) < NUM_CH);
   assign rise       = echo_s2[cur_ch] & ~echo_s3[cur_ch];
   assign fall       = ~echo_s2[cur_ch] & echo_s3[cur_ch];
   assign meas_next  = (&meas_cnt) ? meas_cnt : meas_cnt + 1'b1;
   assign trig_done  = (state == ST_TRIG) && tick && (us_cnt == CNT_W'(TRIG_US - 1));
   assign tmo_hit    = (state == ST_WAIT_RISE || state == ST_MEASURE) && tick &&
                       (us_cnt == CNT_W'(TIMEOUT_US - 1));
   assign gap_done   = (state == ST_GAP) && tick && (us_cnt == CNT_W'(GAP_US - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Timeout is checked ahead of the echo edges so a coincident rise/fall loses to it.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:      if ((MODE || START) && any_en) next_state = ST_TRIG;
         ST_TRIG:      if (trig_done) next_state = ST_WAIT_RISE;
         ST_WAIT_RISE: begin
            if (tmo_hit)   next_state = ST_GAP;
            else if (rise) next_state = ST_MEASURE;
         end
         ST_MEASURE:   if (tmo_hit || fall) next_state = ST_GAP;
         ST_GAP: begin
            if (gap_done) begin
               if (any_en && (has_next || MODE)) next_state = ST_TRIG;
               else                              next_state = ST_IDLE;
            end
         end
         default:      next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      TRIG = '0;
      BUSY = (state != ST_IDLE);
      clr  = (next_state == ST_TRIG) && (state != ST_TRIG);
      if (state == ST_TRIG) TRIG[cur_ch] = 1'b1;
   end

   // us_cnt is one shared timer: TRIG width, then the rise+measure budget, then GAP.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cur_ch   <= '0;
         us_cnt   <= '0;
         meas_cnt <= '0;
         range_r  <= '0;
         tmo_r    <= '0;
         vld_r    <= '0;
         done_r   <= 1'b0;
      end else begin
         vld_r  <= '0;
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (next_state == ST_TRIG) cur_ch <= CH_W'(first_pick);
            end
            ST_TRIG: begin
               if (tick) us_cnt <= trig_done ? '0 : us_cnt + 1'b1;
            end
            ST_WAIT_RISE, ST_MEASURE: begin
               if (tick) us_cnt <= us_cnt + 1'b1;
               if (state == ST_MEASURE && tick) meas_cnt <= meas_next;
               if (tmo_hit) begin
                  us_cnt                            <= '0;
                  range_r[cur_ch*DIST_W +: DIST_W] <= '1;
                  tmo_r[cur_ch]                     <= 1'b1;
                  vld_r[cur_ch]                     <= 1'b1;
               end else if (state == ST_WAIT_RISE && rise) begin
                  meas_cnt <= '0;
               end else if (state == ST_MEASURE && fall) begin
                  us_cnt                            <= '0;
                  range_r[cur_ch*DIST_W +: DIST_W] <= tick ? meas_next : meas_cnt;
                  tmo_r[cur_ch]                     <= 1'b0;
                  vld_r[cur_ch]                     <= 1'b1;
               end
            end
            ST_GAP: begin
               if (tick) us_cnt <= us_cnt + 1'b1;
               if (gap_done) begin
                  us_cnt <= '0;
                  if (any_en) begin
                     if (has_next) begin
                        cur_ch <= CH_W'(next_pick);
                     end else begin
                        done_r <= 1'b1;
                        if (MODE) cur_ch <= CH_W'(first_pick);
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign CUR_CH     = cur_ch;
   assign RANGE      = range_r;
   assign TMO        = tmo_r;
   assign RANGE_VLD  = vld_r;
   assign SWEEP_DONE = done_r;

endmodule

// File: tb/tb_multi_echo_ranger.sv
// Directed + randomized bench: per-channel echo responders driven from a schedule,
// results compared against the expected width/timeout outcome of each schedule.
`timescale 1ns/1ps
module tb_multi_echo_ranger;

   localparam int NCH      = 4;
   localparam int TDIV     = 2;
   localparam int TRIG_US  = 10;
   localparam int TMO_US   = 400;
   localparam int GAP_US   = 20;
   localparam int DW       = 8;
   localparam int RMAX     = (1 << DW) - 1;
   localparam int TRIG_CYC = TRIG_US * TDIV;

   logic           clk = 1'b0, rst_n = 1'b0, mode = 1'b0, start = 1'b0;
   logic [NCH-1:0] ch_en = '0, echo_man = '0;
   logic [NCH-1:0] resp_lvl, resp_act, echo;
   logic [NCH-1:0] trig, range_vld, tmo;
   logic           busy, sweep_done;
   logic [1:0]     cur_ch;
   logic [NCH*DW-1:0] rng;

   assign echo = resp_lvl | echo_man;
   always #5 clk = ~clk;

   multi_echo_ranger #(
      .NUM_CH(NCH), .TICK_DIV(TDIV), .TRIG_US(TRIG_US),
      .TIMEOUT_US(TMO_US), .GAP_US(GAP_US), .DIST_W(DW)
   ) dut (
      .CLK(clk), .RESET_N(rst_n), .MODE(mode), .START(start), .CH_EN(ch_en),
      .ECHO(echo), .TRIG(trig), .BUSY(busy), .CUR_CH(cur_ch), .RANGE(rng),
      .RANGE_VLD(range_vld), .TMO(tmo), .SWEEP_DONE(sweep_done)
   );

   int checks = 0, failures = 0;
   bit resp_on [NCH];
   int resp_d [NCH], resp_w [NCH];
   int exp_rng [NCH], exp_tol [NCH];
   bit exp_tmo [NCH];

   int vld_cnt [NCH];
   int done_cnt = 0, onehot_err = 0, trig_bad = 0, busy_cnt = 0, trig_run = 0;

   // Each responder answers its own TRIG fall: wait d us, then hold ECHO high for w us.
   for (genvar k = 0; k < NCH; k++) begin : g_resp
      logic lvl = 1'b0;
      logic act = 1'b0;
      assign resp_lvl[k] = lvl;
      assign resp_act[k] = act;
      initial begin
         forever begin
            @(negedge trig[k]);
            if (rst_n && resp_on[k]) begin
               act = 1'b1;
               repeat (resp_d[k] * TDIV) @(negedge clk);
               lvl = 1'b1;
               repeat (resp_w[k] * TDIV) @(negedge clk);
               lvl = 1'b0;
               act = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if ($countones(trig) > 1) onehot_err <= onehot_err + 1;
      if (trig != '0) begin
         trig_run <= trig_run + 1;
      end else if (trig_run != 0) begin
         trig_run <= 0;
         if (trig_run != TRIG_CYC) trig_bad <= trig_bad + 1;
      end
      for (int k = 0; k < NCH; k++) if (range_vld[k]) vld_cnt[k] <= vld_cnt[k] + 1;
      if (sweep_done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int expv, input int tol);
      checks++;
      assert (obs >= expv - tol && obs <= expv + tol) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, expv, tol);
      end
   endtask

   // Expected outcome of a channel's schedule: timeout if no rise or the echo outlasts the budget.
   function automatic void model(input int k);
      if (!resp_on[k] || resp_d[k] + resp_w[k] > TMO_US) begin
         exp_rng[k] = RMAX; exp_tmo[k] = 1'b1; exp_tol[k] = 0;
      end else if (resp_w[k] > RMAX) begin
         exp_rng[k] = RMAX; exp_tmo[k] = 1'b0; exp_tol[k] = 0;
      end else begin
         exp_rng[k] = resp_w[k]; exp_tmo[k] = 1'b0; exp_tol[k] = 1;
      end
   endfunction

   task automatic set_resp(input int k, input bit on, input int d, input int w);
      resp_on[k] = on; resp_d[k] = d; resp_w[k] = w;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'(0));
      @(negedge clk);
      #1;
   endtask

   task automatic wait_resp();
      int n = 0;
      while (resp_act != '0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic chk_results(input string tag);
      for (int k = 0; k < NCH; k++) begin
         chk_near($sformatf("%s_rng%0d", tag, k), int'(rng[k*DW +: DW]), exp_rng[k], exp_tol[k]);
         chk($sformatf("%s_tmo%0d", tag, k), 32'(tmo[k]), 32'(exp_tmo[k]));
      end
   endtask

   task automatic do_sweep(input logic [NCH-1:0] en, input string tag, input bit restart,
                           input logic [NCH-1:0] noise);
      int v0 [NCH];
      int d0, oh0, tb0;
      for (int k = 0; k < NCH; k++) v0[k] = vld_cnt[k];
      d0 = done_cnt; oh0 = onehot_err; tb0 = trig_bad;
      ch_en = en;
      pulse_start();
      repeat (30) @(negedge clk);
      echo_man = echo_man ^ noise;
      if (restart) pulse_start();
      repeat (30) @(negedge clk);
      echo_man = echo_man ^ noise;
      wait_idle(tag, 20000);
      wait_resp();
      for (int k = 0; k < NCH; k++) if (en[k]) model(k);
      chk_results(tag);
      for (int k = 0; k < NCH; k++)
         chk($sformatf("%s_vld%0d", tag, k), 32'(vld_cnt[k] - v0[k]), 32'(en[k] ? 1 : 0));
      chk({tag, "_done"}, 32'(done_cnt - d0), 32'(1));
      chk({tag, "_onehot"}, 32'(onehot_err - oh0), 32'(0));
      chk({tag, "_trigw"}, 32'(trig_bad - tb0), 32'(0));
   endtask

   initial begin
      int n, base, b2, v1, kind;
      logic [NCH-1:0] en;

      for (int k = 0; k < NCH; k++) begin
         set_resp(k, 1'b0, 1, 1);
         exp_rng[k] = 0; exp_tmo[k] = 1'b0; exp_tol[k] = 0;
      end

      repeat (3) @(negedge clk);
      chk("rst_trig", 32'(trig), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_range", 32'(rng), 32'(0));
      chk("rst_tmo", 32'(tmo), 32'(0));
      chk("rst_vld", 32'(range_vld), 32'(0));
      chk("rst_done", 32'(sweep_done), 32'(0));
      chk("rst_curch", 32'(cur_ch), 32'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic single-shot sweep over channels 0 and 2.
      set_resp(0, 1'b1, 4, 58);
      set_resp(2, 1'b1, 3, 120);
      do_sweep(4'b0101, "basic", 1'b0, '0);
      chk("basic_curch", 32'(cur_ch), 32'(2));

      // Timeouts: no echo at all, and an echo outlasting the budget.
      set_resp(1, 1'b0, 1, 1);
      do_sweep(4'b0010, "noecho", 1'b0, '0);
      set_resp(0, 1'b1, 5, 440);
      do_sweep(4'b0001, "longecho", 1'b0, '0);

      for (int it = 0; it < 5; it++) begin
         en = 4'($urandom_range(1, 15));
         for (int k = 0; k < NCH; k++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
               0:       set_resp(k, 1'b0, 1, 1);
               1:       set_resp(k, 1'b1, int'($urandom_range(1, 40)), int'($urandom_range(2, 250)));
               2:       set_resp(k, 1'b1, int'($urandom_range(1, 40)), int'($urandom_range(430, 470)));
               default: set_resp(k, 1'b1, int'($urandom_range(1, 20)), int'($urandom_range(270, 360)));
            endcase
         end
         do_sweep(en, $sformatf("rnd%0d", it), 1'b0, ~en);
      end

      // Continuous mode: drop MODE once three sweeps completed; the fourth must finish.
      set_resp(0, 1'b1, 2, 20);
      set_resp(1, 1'b1, 2, 20);
      ch_en = 4'b0011;
      base = done_cnt;
      mode = 1'b1;
      n = 0;
      while (done_cnt - base < 3 && n < 20000) begin
         @(negedge clk);
         #1;
         n++;
      end
      mode = 1'b0;
      chk("cont_three", 32'(done_cnt - base), 32'(3));
      wait_idle("cont", 20000);
      wait_resp();
      chk("cont_total", 32'(done_cnt - base), 32'(4));
      model(0); model(1);
      chk_results("cont");

      // Mask cleared during GAP ends the sweep before channel 1 is addressed.
      v1 = vld_cnt[1];
      base = vld_cnt[0];
      mode = 1'b1;
      n = 0;
      while (vld_cnt[0] == base && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("gapoff_vld0", 32'(vld_cnt[0] - base), 32'(1));
      ch_en = '0;
      wait_idle("gapoff", 5000);
      mode = 1'b0;
      wait_resp();
      chk("gapoff_vld1", 32'(vld_cnt[1] - v1), 32'(0));
      model(0);
      chk_results("gapoff");

      // Asynchronous reset in the middle of a measurement.
      set_resp(0, 1'b1, 5, 200);
      ch_en = 4'b0001;
      pulse_start();
      repeat ((TRIG_US + 5 + 50) * TDIV) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("amid_trig", 32'(trig), 32'(0));
      chk("amid_busy", 32'(busy), 32'(0));
      chk("amid_range", 32'(rng), 32'(0));
      chk("amid_tmo", 32'(tmo), 32'(0));
      for (int k = 0; k < NCH; k++) begin
         exp_rng[k] = 0; exp_tmo[k] = 1'b0; exp_tol[k] = 0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_resp();
      set_resp(0, 1'b1, 3, 77);
      set_resp(3, 1'b1, 6, 33);
      do_sweep(4'b1001, "postrst", 1'b0, '0);

      // START while busy is ignored; noise on unaddressed channels changes nothing.
      set_resp(0, 1'b1, 3, 150);
      do_sweep(4'b0001, "busystart", 1'b1, 4'b1110);

      // START with an empty mask never leaves IDLE.
      ch_en = '0;
      base = done_cnt;
      b2 = busy_cnt;
      pulse_start();
      repeat (10) @(negedge clk);
      #1;
      chk("nomask_busy", 32'(busy_cnt - b2), 32'(0));
      chk("nomask_done", 32'(done_cnt - base), 32'(0));

      // ECHO already high at TRIG fall with no later rise ends in timeout.
      set_resp(0, 1'b0, 1, 1);
      echo_man[0] = 1'b1;
      do_sweep(4'b0001, "echohigh", 1'b0, '0);
      echo_man[0] = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
